// File: rtl/bpsk_tx_scheduler.sv
// Two-requester round-robin word scheduler feeding a BPSK modulator, LSB first.
// Optional preamble symbols before each word when BPSK_TX_PREAMBLE_EN is defined.
module bpsk_tx_scheduler #(
   parameter int WORD_WIDTH    = 9,
   parameter int PHASE_WIDTH   = 8,
   parameter int PREAMBLE_BITS = 4
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   en,
   input  logic                   req0_valid,
   input  logic                   req1_valid,
   input  logic [WORD_WIDTH-1:0]  req0_data,
   input  logic [WORD_WIDTH-1:0]  req1_data,
   output logic                   req0_ready,
   output logic                   req1_ready,
   output logic                   mod_en,
   output logic                   mod_bit,
   output logic [PHASE_WIDTH-1:0] mod_phase,
   output logic                   busy,
   output logic                   grant_id
);

   localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam logic [BIT_W-1:0]       LAST_BIT   = BIT_W'(WORD_WIDTH - 1);
   localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = '1;
`ifdef BPSK_TX_PREAMBLE_EN
   localparam int PRE_W = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
   localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(PREAMBLE_BITS - 1);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1
`ifdef BPSK_TX_PREAMBLE_EN
      , PREAMBLE = 2'd2
`endif
   } state_t;

   state_t                 r_state,   w_nextState;
   logic [WORD_WIDTH-1:0]  r_shift,   w_nextShift;
   logic [BIT_W-1:0]       r_bitIdx,  w_nextBitIdx;
   logic [PHASE_WIDTH-1:0] r_phase,   w_nextPhase;
   logic                   r_modBit,  w_nextModBit;
   logic                   r_grantId, w_nextGrantId;
   logic                   r_lastGrant, w_nextLastGrant;
`ifdef BPSK_TX_PREAMBLE_EN
   logic [PRE_W-1:0]       r_preIdx,  w_nextPreIdx;
`endif

   logic                  w_symEnd;
   logic                  w_slot;
   logic                  w_win1;
   logic                  w_take;
   logic [WORD_WIDTH-1:0] w_word;

   // An accept slot is either idle or the very last sample of the final data bit,
   // which is what lets back-to-back words run without a gap.
   assign w_symEnd = en && (r_phase == LAST_PHASE);
   assign w_slot   = !arst && ((r_state == IDLE) ||
                               ((r_state == SEND) && w_symEnd && (r_bitIdx == LAST_BIT)));
   assign w_win1   = req1_valid && (!req0_valid || !r_lastGrant);
   assign req0_ready = w_slot && req0_valid && !w_win1;
   assign req1_ready = w_slot && w_win1;
   assign w_take   = req0_ready || req1_ready;
   assign w_word   = w_win1 ? req1_data : req0_data;

   assign busy      = (r_state != IDLE);
   assign mod_en    = en && busy;
   assign mod_bit   = r_modBit;
   assign mod_phase = r_phase;
   assign grant_id  = r_grantId;

   // Next-state logic; a transfer overrides whatever the symbol sequencing decided.
   always_comb begin
      w_nextState     = r_state;
      w_nextShift     = r_shift;
      w_nextBitIdx    = r_bitIdx;
      w_nextPhase     = r_phase;
      w_nextModBit    = r_modBit;
      w_nextGrantId   = r_grantId;
      w_nextLastGrant = r_lastGrant;
`ifdef BPSK_TX_PREAMBLE_EN
      w_nextPreIdx    = r_preIdx;
`endif
      case (r_state)
         IDLE: begin
         end
         SEND: begin
            if (en) w_nextPhase = r_phase + 1'b1;
            if (w_symEnd) begin
               if (r_bitIdx == LAST_BIT) begin
                  w_nextState  = IDLE;
                  w_nextModBit = 1'b0;
                  w_nextBitIdx = '0;
               end else begin
                  w_nextBitIdx = r_bitIdx + 1'b1;
                  w_nextShift  = r_shift >> 1;
                  w_nextModBit = r_shift[1];
               end
            end
         end
`ifdef BPSK_TX_PREAMBLE_EN
         PREAMBLE: begin
            if (en) w_nextPhase = r_phase + 1'b1;
            if (w_symEnd) begin
               if (r_preIdx == LAST_PRE) begin
                  w_nextState  = SEND;
                  w_nextPreIdx = '0;
                  w_nextModBit = r_shift[0];
               end else begin
                  w_nextPreIdx = r_preIdx + 1'b1;
                  w_nextModBit = ~r_modBit;
               end
            end
         end
`endif
         default: w_nextState = IDLE;
      endcase
      if (w_take) begin
         w_nextShift     = w_word;
         w_nextGrantId   = w_win1;
         w_nextLastGrant = w_win1;
         w_nextBitIdx    = '0;
         w_nextPhase     = '0;
`ifdef BPSK_TX_PREAMBLE_EN
         w_nextState     = PREAMBLE;
         w_nextPreIdx    = '0;
         w_nextModBit    = 1'b1;
`else
         w_nextState     = SEND;
         w_nextModBit    = w_word[0];
`endif
      end
   end

   // State register; last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_bitIdx    <= '0;
         r_phase     <= '0;
         r_modBit    <= 1'b0;
         r_grantId   <= 1'b0;
         r_lastGrant <= 1'b1;
`ifdef BPSK_TX_PREAMBLE_EN
         r_preIdx    <= '0;
`endif
      end else begin
         r_state     <= w_nextState;
         r_shift     <= w_nextShift;
         r_bitIdx    <= w_nextBitIdx;
         r_phase     <= w_nextPhase;
         r_modBit    <= w_nextModBit;
         r_grantId   <= w_nextGrantId;
         r_lastGrant <= w_nextLastGrant;
`ifdef BPSK_TX_PREAMBLE_EN
         r_preIdx    <= w_nextPreIdx;
`endif
      end
   end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Scoreboard bench for bpsk_tx_scheduler: a sample-count model expands each granted
// word into its expected symbol samples, and a monitor compares them as they appear.
module tb_bpsk_tx_scheduler;

   localparam int WW  = 9;
   localparam int PW  = 8;
   localparam int PB  = 4;
   localparam int SPS = 1 << PW;
`ifdef BPSK_TX_PREAMBLE_EN
   localparam int SYMS = PB + WW;
`else
   localparam int SYMS = WW;
`endif

   logic          clk, arst, en;
   logic          req0_valid, req1_valid;
   logic [WW-1:0] req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic          mod_en, mod_bit, busy, grant_id;
   logic [PW-1:0] mod_phase;

   bpsk_tx_scheduler #(.WORD_WIDTH(WW), .PHASE_WIDTH(PW), .PREAMBLE_BITS(PB)) dut (
      .clk(clk), .arst(arst), .en(en),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_data(req0_data), .req1_data(req1_data),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .mod_en(mod_en), .mod_bit(mod_bit), .mod_phase(mod_phase),
      .busy(busy), .grant_id(grant_id)
   );

   typedef struct {bit b; int ph; bit g;} sample_t;
   typedef struct {bit r0; bit r1; bit busy; bit men; int gid;} cyc_t;

   sample_t sampleQ[$];
   cyc_t    cycQ[$];
   int      compared = 0;
   int      mismatched = 0;
   int      samplesLeft = 0;
   bit      lastGrant = 1'b1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void checkOutput(string name, int act, int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Expand a granted word into every sample the modulator should emit for it.
   function automatic void pushWord(logic [WW-1:0] w, bit g);
      sample_t s;
      for (int k = 0; k < SYMS; k++) begin
         for (int p = 0; p < SPS; p++) begin
`ifdef BPSK_TX_PREAMBLE_EN
            s.b = (k < PB) ? ((k % 2) == 0) : w[k - PB];
`else
            s.b = w[k];
`endif
            s.ph = p;
            s.g  = g;
            sampleQ.push_back(s);
         end
      end
   endfunction

   // One cycle of stimulus; the model decides grants and what this cycle should show.
   task automatic applyStimulus(input bit rst, input bit e, input bit v0, input logic [WW-1:0] d0,
                                input bit v1, input logic [WW-1:0] d1, output bit g0, output bit g1);
      cyc_t c;
      bit   slot, w1;
      @(negedge clk);
      arst = rst; en = e;
      req0_valid = v0; req0_data = d0;
      req1_valid = v1; req1_data = d1;
      g0 = 1'b0; g1 = 1'b0;
      if (rst) begin
         c = '{r0: 1'b0, r1: 1'b0, busy: 1'b0, men: 1'b0, gid: 0};
         sampleQ.delete();
         samplesLeft = 0;
         lastGrant = 1'b1;
      end else begin
         slot = (samplesLeft == 0) || (samplesLeft == 1 && e);
         w1   = v1 && (!v0 || !lastGrant);
         g1   = slot && w1;
         g0   = slot && v0 && !w1;
         c = '{r0: g0, r1: g1, busy: (samplesLeft > 0), men: e && (samplesLeft > 0), gid: -1};
         if (c.men) samplesLeft--;
         if (g0 || g1) begin
            pushWord(g1 ? d1 : d0, g1);
            samplesLeft = SYMS * SPS;
            lastGrant = g1;
         end
      end
      cycQ.push_back(c);
   endtask

   // Monitor: compares each cycle's outputs and pops a sample whenever mod_en is up.
   initial begin
      cyc_t    c;
      sample_t s;
      forever begin
         @(negedge clk);
         #2;
         if (cycQ.size() > 0) begin
            c = cycQ.pop_front();
            checkOutput("req0_ready", int'(req0_ready), int'(c.r0));
            checkOutput("req1_ready", int'(req1_ready), int'(c.r1));
            checkOutput("busy", int'(busy), int'(c.busy));
            checkOutput("mod_en", int'(mod_en), int'(c.men));
            if (c.gid >= 0) checkOutput("grant_id_reset", int'(grant_id), c.gid);
            if (!c.busy) begin
               checkOutput("idle_phase", int'(mod_phase), 0);
               checkOutput("idle_bit", int'(mod_bit), 0);
            end
            if (mod_en) begin
               if (sampleQ.size() == 0) begin
                  checkOutput("sample_underflow", 1, 0);
               end else begin
                  s = sampleQ.pop_front();
                  checkOutput("mod_bit", int'(mod_bit), int'(s.b));
                  checkOutput("mod_phase", int'(mod_phase), s.ph);
                  checkOutput("grant_id", int'(grant_id), int'(s.g));
               end
            end
         end
      end
   end

   task automatic idleCycles(input int n, input bit e);
      bit g0, g1;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, e, 1'b0, '0, 1'b0, '0, g0, g1);
   endtask

   task automatic offer0(input logic [WW-1:0] w);
      bit g0, g1;
      int n = 0;
      do begin
         applyStimulus(1'b0, 1'b1, 1'b1, w, 1'b0, '0, g0, g1);
         n++;
      end while (!g0 && n < 6000);
      if (!g0) checkOutput("offer0_timeout", 0, 1);
   endtask

   initial begin
      bit g0, g1, got0, got1;
      int n, cnt;
      logic [WW-1:0] d;
      arst = 1'b1; en = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;

      // Reset: outputs idle and ready low even with both requesters valid.
      applyStimulus(1'b1, 1'b1, 1'b1, 9'h055, 1'b1, 9'h0AA, g0, g1);
      applyStimulus(1'b1, 1'b0, 1'b1, 9'h055, 1'b1, 9'h0AA, g0, g1);
      idleCycles(3, 1'b1);

      // Single word 0x1A5 offered once.
      offer0(9'h1A5);
      idleCycles(SYMS * SPS + 20, 1'b1);

      // Both valid: req0 first, then req1 gapless.
      got0 = 0; got1 = 0; n = 0;
      while (!(got0 && got1) && n < 8000) begin
         applyStimulus(1'b0, 1'b1, !got0, 9'h001, !got1, 9'h100, g0, g1);
         got0 |= g0; got1 |= g1; n++;
      end
      if (!(got0 && got1)) checkOutput("tie_timeout", 0, 1);
      idleCycles(SYMS * SPS + 20, 1'b1);

      // en stalls mid-symbol.
      offer0(9'h0F3);
      idleCycles(38, 1'b1);
      idleCycles(2, 1'b0);
      idleCycles(SYMS * SPS, 1'b1);

      // Reset mid-word, then a fresh word restarts at bit 0.
      offer0(9'h13C);
      idleCycles(4 * SPS + 100, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, g0, g1);
      idleCycles(2, 1'b1);
      offer0(9'h0C7);
      idleCycles(SYMS * SPS + 20, 1'b1);

      // req1 alone for three back-to-back words.
      cnt = 0; n = 0; d = 9'h111;
      while (cnt < 3 && n < 12000) begin
         applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, d, g0, g1);
         if (g1) begin cnt++; d = d + 9'h05B; end
         n++;
      end
      if (cnt < 3) checkOutput("req1_stream_timeout", cnt, 3);
      idleCycles(SYMS * SPS + 20, 1'b1);

      // Randomized traffic with random en and one reset in the middle.
      for (int i = 0; i < 20000; i++) begin
         applyStimulus(i == 9000, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) == 0, WW'($urandom),
                       $urandom_range(0, 3) == 0, WW'($urandom), g0, g1);
      end
      idleCycles(SYMS * SPS + 20, 1'b1);

      @(negedge clk);
      #5;
      checkOutput("sample_queue_drained", sampleQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bpsk_tx_scheduler.md
BPSK_TX_SCHEDULER -- requirements
Module: bpsk_tx_scheduler

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 9, bits per transmitted word.
REQ-002 SHALL have parameter PHASE_WIDTH, default 8, sine phase index width; samples per symbol = 2**PHASE_WIDTH.
REQ-003 SHALL have parameter PREAMBLE_BITS, default 4, preamble symbol count; used only under REQ-026.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port arst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  sample-rate strobe; one modulator sample per cycle with en=1.
REQ-007 SHALL have ports req0_valid, req1_valid  input  1  word offered by requester 0/1.
REQ-008 SHALL have ports req0_data, req1_data  input  WORD_WIDTH  offered word.
REQ-009 SHALL have ports req0_ready, req1_ready  output  1  word accepted this cycle (combinational).
REQ-010 SHALL have port mod_en  output  1  modulator sample enable.
REQ-011 SHALL have port mod_bit  output  1  current symbol: 1 = +sine, 0 = -sine.
REQ-012 SHALL have port mod_phase  output  PHASE_WIDTH  sine ROM index.
REQ-013 SHALL have port busy  output  1  high when not IDLE.
REQ-014 SHALL have port grant_id  output  1  requester of the word in flight.

Function
REQ-015 SHALL implement FSM states IDLE, PREAMBLE (macro builds only), SEND.
REQ-016 SHALL transfer a word when reqN_valid && reqN_ready; reqN_ready asserts only in accept slots: state IDLE, or last sample of the final SEND bit (phase all-ones, bit index WORD_WIDTH-1, en=1).
REQ-017 SHALL arbitrate round-robin: one valid requester wins; if both valid, the requester not equal to last_grant wins; at most one ready per cycle.
REQ-018 On transfer SHALL latch data into a shift register, set grant_id and last_grant to the winner, clear bit index and phase, enter SEND (or PREAMBLE per REQ-026).
REQ-019 IDLE transfer does not require en; SEND begins on the next en cycle.
REQ-020 In PREAMBLE/SEND, each en cycle SHALL increment mod_phase modulo 2**PHASE_WIDTH; on wrap to 0 advance to next symbol.
REQ-021 SHALL transmit word bits LSB first; mod_bit equals the current bit for all 2**PHASE_WIDTH samples of that symbol.
REQ-022 After the final sample with no transfer in that slot SHALL return to IDLE, mod_phase 0; with a transfer, next word's bit 0 starts on the next en cycle with no idle gap (gapless).
REQ-023 mod_en SHALL equal en && busy; with en=0 all state, mod_phase and mod_bit SHALL hold.
REQ-024 mod_bit, mod_phase, busy, grant_id SHALL be registered; valid deasserting mid-word SHALL not affect the word in flight.

Reset
REQ-025 On arst SHALL force state IDLE, mod_phase 0, mod_bit 0, bit index 0, busy 0, grant_id 0, last_grant 1 (requester 0 wins first tie); reset mid-word discards the word; ready outputs low while arst high.

Configuration
REQ-026 With BPSK_TX_PREAMBLE_EN defined, each transfer SHALL enter PREAMBLE, sending PREAMBLE_BITS symbols alternating 1,0,1,0,... (first symbol 1), then SEND; gapless transfers also get a preamble. Without it, PREAMBLE state and PREAMBLE_BITS logic SHALL be absent and transfers go straight to SEND.

Verification
REQ-027 Defaults, en=1, req0 offers 9'h1A5 once -> req0_ready 1 cycle; mod_bit 1,0,1,0,0,1,0,1,1 each for 256 cycles, mod_phase 0..255 per symbol; busy low after 2304 en cycles.
REQ-028 Both valid from reset, data 9'h001/9'h100 -> req0 granted first, grant_id 0; req1_ready pulses on sample 2303; req1 bit 0 starts next cycle with no gap, grant_id 1.
REQ-029 en toggled 1,0,0,1 mid-symbol at phase 37 -> mod_phase holds 38 for two cycles, mod_en low, then 39.
REQ-030 arst pulsed at bit 4 phase 100 -> immediately busy 0, mod_phase 0, mod_bit 0; next req0 word restarts at bit 0.
REQ-031 BPSK_TX_PREAMBLE_EN defined, PREAMBLE_BITS 4, word 9'h000 -> mod_bit 1,0,1,0 then nine 0 symbols, 3328 en cycles total.
REQ-032 req1 alone held valid for three words -> all three granted to req1 back-to-back, req0_ready never asserted.
